// File: rtl/cplx_alu_pkg.sv
// cplx_alu_pkg: shared definitions for the sequential complex ALU.
//   - op encodings carried on the 2-bit op port
//   - FSM state enum used by cplx_alu_seq
package cplx_alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;  // A + B
  localparam logic [1:0] OP_SUB  = 2'b01;  // A - B
  localparam logic [1:0] OP_MUL  = 2'b10;  // A * B
  localparam logic [1:0] OP_CMUL = 2'b11;  // A * conj(B)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cplx_smul.sv
// cplx_smul: combinational signed W x W multiplier producing a 2W-bit
// signed product.
//   a, b : signed W-bit factors
//   p    : signed 2W-bit product (always representable, no truncation loss)
module cplx_smul #(
  parameter int W = 5
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);

  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] b_ext;

  // Widen both factors first so the multiply is evaluated at full width.
  assign a_ext = {{W{a[W-1]}}, a};
  assign b_ext = {{W{b[W-1]}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/cplx_alu_seq.sv
// cplx_alu_seq: sequential complex ALU (add, sub, mul, conj-mul) with
// valid/ready handshakes on both sides.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : operation handshake for op_a, op_b, op
//   op_a, op_b         : {re, im}, each a signed W-bit component
//   op                 : 00 add, 01 sub, 10 mul, 11 conj-mul
//   out_valid/out_ready: result handshake
//   result             : {re, im}, each signed 2W+1 bits
//   ovf_re, ovf_im     : component does not fit in signed W bits
// Add/sub finish on the accept edge; mul/conj-mul spend four cycles in MUL
// accumulating one partial product per cycle through a single multiplier.
module cplx_alu_seq
  import cplx_alu_pkg::*;
#(
  parameter int W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   op_a,
  input  logic [2*W-1:0]   op_b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*W+1:0]   result,
  output logic             ovf_re,
  output logic             ovf_im
);

  localparam int AW = 2 * W + 1;

  state_t state;
  state_t state_next;

  logic [1:0]            step;
  logic [1:0]            op_q;
  logic [2*W-1:0]        a_q;
  logic [2*W-1:0]        b_q;
  logic signed [AW-1:0]  acc_re;
  logic signed [AW-1:0]  acc_im;

  logic                  accept;
  logic signed [W-1:0]   ar, ai, br, bi;
  logic signed [W-1:0]   mul_x, mul_y;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_ext;
  logic                  negate;
  logic [AW-1:0]         add_re, add_im;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = op[1] ? MUL : DONE;
        end
      end
      MUL: begin
        if (step == 2'd3) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          // A new operation may be taken on the same edge the result leaves.
          if (accept) begin
            state_next = op[1] ? MUL : DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Operand views and the shared multiplier
  // ---------------------------------------------------------------------
  assign ar = a_q[2*W-1:W];
  assign ai = a_q[W-1:0];
  assign br = b_q[2*W-1:W];
  assign bi = b_q[W-1:0];

  always_comb begin
    mul_x = ai;
    mul_y = br;
    case (step)
      2'd0: begin mul_x = ar; mul_y = br; end
      2'd1: begin mul_x = ai; mul_y = bi; end
      2'd2: begin mul_x = ar; mul_y = bi; end
      default: begin mul_x = ai; mul_y = br; end
    endcase
  end

  cplx_smul #(.W(W)) u_smul (
    .a(mul_x),
    .b(mul_y),
    .p(prod)
  );

  assign prod_ext = {prod[2*W-1], prod};

  // ai*bi is subtracted for a plain multiply; ar*bi for a conjugate multiply.
  assign negate = ((step == 2'd1) && (op_q == OP_MUL)) ||
                  ((step == 2'd2) && (op_q == OP_CMUL));

  // Component-wise add/sub computed directly from the incoming operands.
  always_comb begin
    logic [AW-1:0] a_re_ext, a_im_ext, b_re_ext, b_im_ext;
    a_re_ext = {{(W+1){op_a[2*W-1]}}, op_a[2*W-1:W]};
    a_im_ext = {{(W+1){op_a[W-1]}},   op_a[W-1:0]};
    b_re_ext = {{(W+1){op_b[2*W-1]}}, op_b[2*W-1:W]};
    b_im_ext = {{(W+1){op_b[W-1]}},   op_b[W-1:0]};
    if (op == OP_SUB) begin
      add_re = a_re_ext - b_re_ext;
      add_im = a_im_ext - b_im_ext;
    end else begin
      add_re = a_re_ext + b_re_ext;
      add_im = a_im_ext + b_im_ext;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
      step   <= 2'd0;
      acc_re <= '0;
      acc_im <= '0;
    end else if (accept) begin
      a_q  <= op_a;
      b_q  <= op_b;
      op_q <= op;
      step <= 2'd0;
      if (op[1]) begin
        acc_re <= '0;
        acc_im <= '0;
      end else begin
        acc_re <= add_re;
        acc_im <= add_im;
      end
    end else if (state == MUL) begin
      step <= step + 2'd1;
      // Steps 0/1 build the real part, steps 2/3 the imaginary part.
      if (!step[1]) begin
        acc_re <= negate ? (acc_re - prod_ext) : (acc_re + prod_ext);
      end else begin
        acc_im <= negate ? (acc_im - prod_ext) : (acc_im + prod_ext);
      end
    end
  end

  assign result = {acc_re, acc_im};

  // A value fits in signed W bits iff bits [AW-1:W-1] are all equal.
  assign ovf_re = ~((&acc_re[AW-1:W-1]) | ~(|acc_re[AW-1:W-1]));
  assign ovf_im = ~((&acc_im[AW-1:W-1]) | ~(|acc_im[AW-1:W-1]));

endmodule

// File: tb/tb_cplx_alu_seq.sv
module tb_cplx_alu_seq;
  import cplx_alu_pkg::*;

  localparam int W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2*W-1:0]   op_a = '0;
  logic [2*W-1:0]   op_b = '0;
  logic [1:0]       op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [4*W+1:0]   result;
  logic             ovf_re;
  logic             ovf_im;

  cplx_alu_seq #(.W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_a(op_a),
    .op_b(op_b),
    .op(op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .ovf_re(ovf_re),
    .ovf_im(ovf_im)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int re;
    int im;
    int ovr;
    int ovi;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   fresh = 1'b1;
  bit   or_force = 1'b0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int comp(input logic [2*W-1:0] v, input bit hi);
    logic signed [W-1:0] c;
    int r;
    c = hi ? v[2*W-1:W] : v[W-1:0];
    r = c;
    return r;
  endfunction

  function automatic logic [2*W-1:0] pk(input int re, input int im);
    logic [W-1:0] r, i;
    r = re[W-1:0];
    i = im[W-1:0];
    return {r, i};
  endfunction

  function automatic int outside_w(input int v);
    return ((v < -(1 << (W-1))) || (v > (1 << (W-1)) - 1)) ? 1 : 0;
  endfunction

  // Reference: plain complex arithmetic on integers.
  function automatic exp_t model(input logic [1:0] o, input logic [2*W-1:0] a,
                                 input logic [2*W-1:0] b);
    exp_t e;
    int xr, xi, yr, yi;
    xr = comp(a, 1'b1); xi = comp(a, 1'b0);
    yr = comp(b, 1'b1); yi = comp(b, 1'b0);
    case (o)
      OP_ADD:  begin e.re = xr + yr;           e.im = xi + yi;           end
      OP_SUB:  begin e.re = xr - yr;           e.im = xi - yi;           end
      OP_MUL:  begin e.re = xr*yr - xi*yi;     e.im = xr*yi + xi*yr;     end
      default: begin e.re = xr*yr + xi*yi;     e.im = xi*yr - xr*yi;     end
    endcase
    e.ovr = outside_w(e.re);
    e.ovi = outside_w(e.im);
    e.due = 0;
    return e;
  endfunction

  // Random consumer backpressure unless a test drives out_ready itself.
  always @(posedge clk) begin
    #1;
    if (!or_force) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    logic signed [2*W:0] rr, ri;
    int gr, gi;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got out_valid=1, expected no result pending (t=%0t)", $time);
      end else begin
        e  = sb[0];
        rr = result[4*W+1:2*W+1];
        ri = result[2*W:0];
        gr = rr;
        gi = ri;
        if (fresh) begin
          check("latency_cycle", cyc, e.due);
          fresh = 1'b0;
        end
        check("result_re", gr, e.re);
        check("result_im", gi, e.im);
        check("ovf_re", int'(ovf_re), e.ovr);
        check("ovf_im", int'(ovf_im), e.ovi);
        $display("txn out: re=%0d im=%0d ovf=%0b%0b out_ready=%0b", gr, gi, ovf_re, ovf_im, out_ready);
        if (!out_ready) begin
          check("in_ready_while_held", int'(in_ready), 0);
        end else begin
          void'(sb.pop_front());
          fresh = 1'b1;
        end
      end
    end
  end

  // Call just after a rising edge; returns just after the accept edge
  // (for mul ops, after the MUL phase with garbage on the inputs).
  task automatic issue(input logic [1:0] o, input logic [2*W-1:0] a,
                       input logic [2*W-1:0] b, output int waited);
    exp_t e;
    waited = 0;
    in_valid = 1'b1;
    op = o;
    op_a = a;
    op_b = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
        in_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    e = model(o, a, b);
    e.due = cyc + (o[1] ? 5 : 1);
    sb.push_back(e);
    $display("txn in: op=%0d a=(%0d,%0d) b=(%0d,%0d)", o, comp(a, 1'b1), comp(a, 1'b0),
             comp(b, 1'b1), comp(b, 1'b0));
    @(posedge clk); #1;
    if (o[1]) begin
      // Inputs toggling during MUL must be ignored.
      repeat (4) begin
        in_valid = 1'b1;
        op = 2'($urandom);
        op_a = 2*W'($urandom);
        op_b = 2*W'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int w;
    int g;
    logic [1:0] o;

    // Reset state
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(result != '0), 0);
    check("rst_ovf", int'({ovf_re, ovf_im}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Directed vectors
    issue(OP_ADD,  pk(3, -2),   pk(4, 5),     w);
    issue(OP_SUB,  pk(15, 0),   pk(-1, 0),    w);
    issue(OP_MUL,  pk(-16, -16), pk(-16, -16), w);
    issue(OP_CMUL, pk(3, 4),    pk(3, 4),     w);
    drain();

    // Backpressure then back-to-back accept on the release edge
    or_force = 1'b1;
    out_ready = 1'b0;
    issue(OP_MUL, pk(7, -3), pk(-5, 2), w);
    repeat (3) begin @(posedge clk); #1; end
    check("held_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    issue(OP_SUB, pk(-16, 15), pk(15, -16), w);
    check("b2b_wait", w, 0);
    drain();

    // Reset in the middle of a multiply
    in_valid = 1'b1;
    op = OP_MUL;
    op_a = pk(5, 6);
    op_b = pk(7, 8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_result", int'(result != '0), 0);
    sb.delete();
    fresh = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    repeat (8) begin
      @(negedge clk);
      check("midrst_no_stale", int'(out_valid), 0);
    end
    or_force = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      issue(o, 2*W'($urandom), 2*W'($urandom), w);
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cplx_alu_seq.md
CPLX_ALU_SEQ -- requirements
Module: cplx_alu_seq

Interface
REQ-001 Parameter W, default 5: width of each signed two's-complement component (real or imaginary); legal range 4..16.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-004 Port in_valid, input, 1: op_a, op_b and op are valid.
REQ-005 Port in_ready, output, 1: the block can accept an operation this cycle.
REQ-006 Port op_a, input, 2W: operand A; real part in [2W-1:W], imaginary part in [W-1:0].
REQ-007 Port op_b, input, 2W: operand B; same packing as op_a.
REQ-008 Port op, input, 2: operation select; 00 = add, 01 = sub (A-B), 10 = mul (A*B), 11 = conj-mul (A*conj(B)).
REQ-009 Port out_valid, output, 1: result, ovf_re and ovf_im are valid.
REQ-010 Port out_ready, input, 1: the consumer accepts the result this cycle.
REQ-011 Port result, output, 4W+2: full-precision result; real part in [4W+1:2W+1], imaginary part in [2W:0], each signed, 2W+1 bits.
REQ-012 Port ovf_re, output, 1: the real result does not fit in signed W bits.
REQ-013 Port ovf_im, output, 1: the imaginary result does not fit in signed W bits.

Function
REQ-014 The block shall implement FSM states IDLE, MUL and DONE.
REQ-015 An operation is accepted on a clock edge where in_valid=1 and in_ready=1; op_a, op_b and op shall be registered on that edge.
REQ-016 in_ready shall be 1 in IDLE, and 1 in DONE when out_ready=1; in_ready shall be 0 otherwise (always 0 in MUL).
REQ-017 Accepting an add or sub shall move the FSM to DONE, with the component-wise result sign-extended to 2W+1 bits; out_valid rises 1 cycle after the accept edge.
REQ-018 Accepting a mul or conj-mul shall move the FSM to MUL with a 2-bit step counter cleared to 0 and both accumulators cleared.
REQ-019 MUL shall use one shared signed W x W multiplier, one partial product per cycle.
REQ-020 The MUL partial-product sequence shall be:
- step 0: acc_re += ar*br
- step 1: acc_re -= ai*bi (mul) or acc_re += ai*bi (conj-mul)
- step 2: acc_im += ar*bi (mul) or acc_im -= ar*bi (conj-mul)
- step 3: acc_im += ai*br
REQ-021 The edge that accumulates step 3 shall move the FSM to DONE, so out_valid rises 4 cycles after the accept edge.
REQ-022 Accumulators shall be 2W+1 bits wide and signed, so no internal overflow is possible.
REQ-023 In DONE, result, ovf_re and ovf_im shall be held stable until an edge with out_ready=1.
REQ-024 On the out_ready edge, the FSM shall go to IDLE, or directly start the new operation if in_valid=1 on that same edge (back-to-back, no bubble).
REQ-025 ovf_re shall be 1 iff result_re is outside [-2^(W-1), 2^(W-1)-1], and ovf_im likewise for result_im; both flags are computed from the registered result.
REQ-026 out_valid shall be 1 only in DONE.
REQ-027 Changes on in_valid or op while in MUL or DONE shall have no effect.

Reset
REQ-028 While rst_n=0, the FSM shall be IDLE, the counter and accumulators 0, out_valid=0, result=0, ovf_re=0 and ovf_im=0; in_ready=1 once rst_n=1.
REQ-029 Reset asserted mid-MUL or in DONE shall discard the operation; no result is emitted after release.

Structure
REQ-030 Package cplx_alu_pkg shall hold the op encodings (OP_ADD, OP_SUB, OP_MUL, OP_CMUL) and the FSM state enum.
REQ-031 The shared multiplier shall be sub-module cplx_smul: combinational, W x W signed inputs, 2W-bit signed product.

Verification
REQ-032 Add, W=5: A=(3,-2), B=(4,5) -> result=(7,3), ovf=00, out_valid 1 cycle after accept.
REQ-033 Sub, W=5: A=(15,0), B=(-1,0) -> result=(16,0), ovf_re=1, ovf_im=0.
REQ-034 Mul, W=5: A=(-16,-16), B=(-16,-16) -> result=(0,512), ovf_re=0, ovf_im=1, out_valid 4 cycles after accept.
REQ-035 Conj-mul, W=5: A=(3,4), B=(3,4) -> result=(25,0), ovf_re=1.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles in DONE -> result stable and in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted on that same edge.
REQ-037 Reset mid-op: assert rst_n=0 at mul step 2 -> out_valid=0 and result=0 immediately; after release in_ready=1 and no stale result appears.
